// File: rtl/mips_pkg.sv
// Shared definitions for the 5-stage MIPS pipeline: reset constants,
// fetch FSM state encoding, opcode constants and small PC helpers.
package mips_pkg;

  // Architectural constants
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] NOP_INS_DEF  = 32'h0000_0000;

  // Primary opcode field values (ins[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // Fetch FSM states
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_KILL  = 2'd2,
    S_HOLD  = 2'd3
  } fetch_state_t;

  // Sequential successor of a PC; wraps naturally at 2^32
  function automatic logic [31:0] pcPlus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

  // Force a branch target onto a word boundary
  function automatic logic [31:0] wordAlign(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register. Flush wins over load; with neither asserted the
// register holds, which is how a hazard-unit stall freezes the decode input.
module if_id_reg
  import mips_pkg::*;
#(
  parameter logic [31:0] NOP_INS = NOP_INS_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_load,
  input  logic        i_flush,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_ins,
  input  logic        i_valid,
  output logic [31:0] o_pc,
  output logic [31:0] o_ins,
  output logic        o_valid
);

  logic [31:0] r_pc;
  logic [31:0] r_ins;
  logic        r_valid;

  // Register update: flush squashes to a NOP bubble, load captures, else hold
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pc    <= 32'h0000_0000;
      r_ins   <= NOP_INS;
      r_valid <= 1'b0;
    end else if (i_flush) begin
      r_ins   <= NOP_INS;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_pc    <= i_pc;
      r_ins   <= i_ins;
      r_valid <= i_valid;
    end
  end

  assign o_pc    = r_pc;
  assign o_ins   = r_ins;
  assign o_valid = r_valid;

endmodule

// File: rtl/fetch_stage.sv
// IF stage: owns the PC, runs the instruction-memory request/ready handshake
// and feeds the IF/ID register. A taken branch redirects the PC and squashes
// the wrong-path fetch (no delay slot). A fetch that is still waiting when a
// branch arrives is allowed to finish in S_KILL and its data is dropped, so
// the memory sees a stable address for every request it was given.
module fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] NOP_INS  = NOP_INS_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall,
  input  logic        branch,
  input  logic [31:0] branch_address,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_ins,
  output logic        if_id_valid
);

  fetch_state_t r_state;
  logic [31:0]  r_pc;
  logic         r_req;
  logic [31:0]  r_redir;
  logic [31:0]  r_holdPc;
  logic [31:0]  r_holdIns;

  logic         w_branchTaken;
  logic [31:0]  w_target;
  logic         w_unused_addr_bits;
  logic         w_ifidLoad;
  logic         w_ifidFlush;
  logic [31:0]  w_ifidPc;
  logic [31:0]  w_ifidIns;
  logic         w_ifidValid;

  // A branch only counts for a real instruction that is free to move on
  assign w_branchTaken      = branch & if_id_valid & ~stall;
  assign w_target           = wordAlign(branch_address);
  assign w_unused_addr_bits = ^branch_address[1:0];

  // IF/ID control: bubble on a wait state, capture on data, replay hold_q after a stall
  always_comb begin
    w_ifidLoad  = 1'b0;
    w_ifidFlush = 1'b0;
    w_ifidPc    = r_pc;
    w_ifidIns   = NOP_INS;
    w_ifidValid = 1'b0;
    case (r_state)
      S_FETCH: begin
        if (w_branchTaken) begin
          w_ifidFlush = 1'b1;
        end else if (!stall) begin
          w_ifidLoad = 1'b1;
          if (imem_ready) begin
            w_ifidIns   = imem_rdata;
            w_ifidValid = 1'b1;
          end
        end
      end
      S_HOLD: begin
        if (w_branchTaken) begin
          w_ifidFlush = 1'b1;
        end else if (!stall) begin
          w_ifidLoad  = 1'b1;
          w_ifidPc    = r_holdPc;
          w_ifidIns   = r_holdIns;
          w_ifidValid = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Fetch FSM with PC, redirect target, stall capture and registered request
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_pc      <= RESET_PC;
      r_req     <= 1'b0;
      r_redir   <= 32'h0000_0000;
      r_holdPc  <= 32'h0000_0000;
      r_holdIns <= NOP_INS;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_state <= S_FETCH;
          r_req   <= 1'b1;
        end
        S_FETCH: begin
          if (w_branchTaken) begin
            if (imem_ready) begin
              r_pc <= w_target;
            end else begin
              r_redir <= w_target;
              r_state <= S_KILL;
            end
          end else if (stall) begin
            if (imem_ready) begin
              r_holdPc  <= r_pc;
              r_holdIns <= imem_rdata;
              r_pc      <= pcPlus4(r_pc);
              r_state   <= S_HOLD;
              r_req     <= 1'b0;
            end
          end else if (imem_ready) begin
            r_pc <= pcPlus4(r_pc);
          end
        end
        S_KILL: begin
          if (imem_ready) begin
            r_pc    <= r_redir;
            r_state <= S_FETCH;
          end
        end
        S_HOLD: begin
          if (w_branchTaken) begin
            r_pc    <= w_target;
            r_state <= S_FETCH;
            r_req   <= 1'b1;
          end else if (!stall) begin
            r_state <= S_FETCH;
            r_req   <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req  = r_req;
  assign imem_addr = r_pc;

  if_id_reg #(
    .NOP_INS(NOP_INS)
  ) u_if_id_reg (
    .clk     (clk),
    .reset_n (reset_n),
    .i_load  (w_ifidLoad),
    .i_flush (w_ifidFlush),
    .i_pc    (w_ifidPc),
    .i_ins   (w_ifidIns),
    .i_valid (w_ifidValid),
    .o_pc    (if_id_pc),
    .o_ins   (if_id_ins),
    .o_valid (if_id_valid)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios followed by a
// randomized run judged against a program-order reference model.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        clk;
  logic        reset_n;
  logic        stall;
  logic        branch;
  logic [31:0] branch_address;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_ins;
  logic        if_id_valid;

  int errors = 0;
  int checks = 0;

  // Instruction memory contents: a distinct, non-NOP word for each address
  function automatic logic [31:0] memWord(input logic [31:0] addr);
    return {~addr[15:0], addr[31:16]} ^ 32'h1357_9BDF;
  endfunction

  assign imem_rdata = memWord(imem_addr);

  fetch_stage dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .stall          (stall),
    .branch         (branch),
    .branch_address (branch_address),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rdata     (imem_rdata),
    .if_id_pc       (if_id_pc),
    .if_id_ins      (if_id_ins),
    .if_id_valid    (if_id_valid)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, clock it, and settle 1 ns past the edge
  task automatic applyStimulus(input logic s, input logic b, input logic [31:0] tgt, input logic r);
    stall          = s;
    branch         = b;
    branch_address = tgt;
    imem_ready     = r;
    @(posedge clk);
    #1;
  endtask

  task automatic checkIfId(input string tag, input logic [31:0] pc, input logic v);
    checkOutput({tag, "_valid"}, {31'b0, if_id_valid}, {31'b0, v});
    checkOutput({tag, "_pc"}, if_id_pc, pc);
    checkOutput({tag, "_ins"}, if_id_ins, v ? memWord(pc) : NOP);
  endtask

  logic [31:0] nextPc;
  logic [31:0] bPc, bIns, bAddr, tgt;
  logic        bValid, bReq, s, r, takeBr, br;
  int          idle;

  initial begin
    reset_n = 1'b0; stall = 1'b0; branch = 1'b0; branch_address = '0; imem_ready = 1'b0;
    $display("[TB] start");

    // 1: reset state, then reset asserted mid-fetch
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("rst_req", {31'b0, imem_req}, 32'd0);
    checkOutput("rst_valid", {31'b0, if_id_valid}, 32'd0);
    checkOutput("rst_ins", if_id_ins, NOP);
    checkOutput("rst_pc", if_id_pc, 32'd0);
    reset_n = 1'b1;
    checkOutput("idle_req", {31'b0, imem_req}, 32'd0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("fetch_req", {31'b0, imem_req}, 32'd1);
    reset_n = 1'b0;
    #1;
    checkOutput("midrst_req", {31'b0, imem_req}, 32'd0);
    checkOutput("midrst_valid", {31'b0, if_id_valid}, 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    checkOutput("rel_idle_req", {31'b0, imem_req}, 32'd0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("first_req", {31'b0, imem_req}, 32'd1);
    checkOutput("first_addr", imem_addr, 32'h0);
    checkOutput("first_valid", {31'b0, if_id_valid}, 32'd0);

    // 2: zero-wait stream
    applyStimulus(0, 0, 0, 1); checkIfId("s0", 32'h0, 1'b1);
    applyStimulus(0, 0, 0, 1); checkIfId("s4", 32'h4, 1'b1);
    applyStimulus(0, 0, 0, 1); checkIfId("s8", 32'h8, 1'b1);
    checkOutput("s_addr", imem_addr, 32'hC);
    applyStimulus(0, 0, 0, 1);
    applyStimulus(0, 0, 0, 1); checkIfId("s10", 32'h10, 1'b1);

    // 3: branch with the wrong-path fetch completing in the same cycle
    applyStimulus(0, 1, 32'h40, 1);
    checkOutput("br_valid", {31'b0, if_id_valid}, 32'd0);
    checkOutput("br_ins", if_id_ins, NOP);
    checkOutput("br_addr", imem_addr, 32'h40);
    applyStimulus(0, 0, 0, 0); checkIfId("bubble", 32'h40, 1'b0);
    applyStimulus(0, 0, 0, 1); checkIfId("t40", 32'h40, 1'b1);
    applyStimulus(0, 0, 0, 1); checkIfId("t44", 32'h44, 1'b1);

    // 4: branch while the fetch at 0x48 has three wait states
    applyStimulus(0, 1, 32'h80, 0);
    checkOutput("kill_addr0", imem_addr, 32'h48);
    checkOutput("kill_valid0", {31'b0, if_id_valid}, 32'd0);
    applyStimulus(0, 1, 32'h80, 0);
    checkOutput("kill_addr1", imem_addr, 32'h48);
    applyStimulus(0, 0, 0, 0);
    checkOutput("kill_addr2", imem_addr, 32'h48);
    checkOutput("kill_req", {31'b0, imem_req}, 32'd1);
    applyStimulus(0, 0, 0, 1);
    checkOutput("kill_done_addr", imem_addr, 32'h80);
    checkOutput("kill_done_valid", {31'b0, if_id_valid}, 32'd0);
    applyStimulus(0, 0, 0, 1); checkIfId("t80", 32'h80, 1'b1);

    // 5: two-cycle stall while the word at 0x84 returns
    applyStimulus(1, 0, 0, 1);
    checkIfId("stall0", 32'h80, 1'b1);
    checkOutput("stall0_req", {31'b0, imem_req}, 32'd0);
    applyStimulus(1, 0, 0, 0);
    checkIfId("stall1", 32'h80, 1'b1);
    applyStimulus(0, 0, 0, 0);
    checkIfId("unstall", 32'h84, 1'b1);
    checkOutput("unstall_addr", imem_addr, 32'h88);
    checkOutput("unstall_req", {31'b0, imem_req}, 32'd1);

    // 6: PC wrap and unaligned branch target
    applyStimulus(0, 1, 32'hFFFF_FFFC, 1);
    checkOutput("top_addr", imem_addr, 32'hFFFF_FFFC);
    applyStimulus(0, 0, 0, 1);
    checkIfId("top", 32'hFFFF_FFFC, 1'b1);
    checkOutput("wrap_addr", imem_addr, 32'h0);
    applyStimulus(0, 1, 32'h43, 1);
    checkOutput("align_addr", imem_addr, 32'h40);

    // Randomized run: every delivered instruction must be the next one in program order
    reset_n = 1'b0;
    applyStimulus(0, 0, 0, 0);
    reset_n = 1'b1;
    nextPc = 32'h0;
    idle   = 0;
    for (int i = 0; i < 600; i++) begin
      s      = ($urandom_range(0, 4) == 0);
      r      = imem_req && ($urandom_range(0, 9) < 6);
      takeBr = if_id_valid && !s && ($urandom_range(0, 6) == 0);
      br     = takeBr || (s && ($urandom_range(0, 2) == 0));
      tgt    = $urandom;
      bPc = if_id_pc; bIns = if_id_ins; bValid = if_id_valid;
      bReq = imem_req; bAddr = imem_addr;
      applyStimulus(s, br, tgt, r);
      if (s) begin
        checkOutput("rnd_hold_pc", if_id_pc, bPc);
        checkOutput("rnd_hold_ins", if_id_ins, bIns);
        checkOutput("rnd_hold_valid", {31'b0, if_id_valid}, {31'b0, bValid});
      end else if (takeBr) begin
        checkOutput("rnd_flush_valid", {31'b0, if_id_valid}, 32'd0);
        checkOutput("rnd_flush_ins", if_id_ins, NOP);
        nextPc = {tgt[31:2], 2'b00};
      end else if (if_id_valid) begin
        checkOutput("rnd_order_pc", if_id_pc, nextPc);
        checkOutput("rnd_order_ins", if_id_ins, memWord(nextPc));
        nextPc = nextPc + 32'd4;
        idle = 0;
      end else begin
        checkOutput("rnd_bubble_ins", if_id_ins, NOP);
      end
      if (bReq && !r) begin
        checkOutput("rnd_req_hold", {31'b0, imem_req}, 32'd1);
        checkOutput("rnd_addr_stable", imem_addr, bAddr);
      end
      if (imem_req) checkOutput("rnd_align", {30'b0, imem_addr[1:0]}, 32'd0);
      idle++;
      if (idle > 60) begin
        checkOutput("rnd_liveness", idle, 32'd0);
        break;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
